// File: rtl/e203_exu_wbck_arb_pkg.sv
// Shared sizing constants for the write-back arbiter slice.
package e203_exu_wbck_arb_pkg;

    localparam int XLEN       = 32;
    localparam int RFIDX_W    = 5;
    localparam int LQ_DEPTH   = 2;
    localparam int STARVE_MAX = 4;
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

endpackage

// File: rtl/e203_exu_wbck_arb_if.sv
// Bundle of the ALU, long-pipe, regfile write and queue status signals
// seen by the write-back arbiter. The arbiter uses the slave view.
interface e203_exu_wbck_arb_if
    import e203_exu_wbck_arb_pkg::*;
();

    logic               alu_wbck_valid;
    logic               alu_wbck_ready;
    logic [RFIDX_W-1:0] alu_wbck_idx;
    logic [XLEN-1:0]    alu_wbck_dat;

    logic               lp_wbck_valid;
    logic               lp_wbck_ready;
    logic [RFIDX_W-1:0] lp_wbck_idx;
    logic [XLEN-1:0]    lp_wbck_dat;

    logic               rf_wbck_wen;
    logic [RFIDX_W-1:0] rf_wbck_idx;
    logic [XLEN-1:0]    rf_wbck_dat;

    logic               lq_empty;

    modport slave (
        input  alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
        output alu_wbck_ready,
        input  lp_wbck_valid, lp_wbck_idx, lp_wbck_dat,
        output lp_wbck_ready,
        output rf_wbck_wen, rf_wbck_idx, rf_wbck_dat,
        output lq_empty
    );

    modport master (
        output alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
        input  alu_wbck_ready,
        output lp_wbck_valid, lp_wbck_idx, lp_wbck_dat,
        input  lp_wbck_ready,
        input  rf_wbck_wen, rf_wbck_idx, rf_wbck_dat,
        input  lq_empty
    );

endinterface

// File: rtl/e203_exu_wbck_lq.sv
// Long-pipe result queue: a small FIFO of (idx, dat) pairs using
// wrap-bit pointers. Ready is the registered-state !full only, so a pop
// in the same cycle never opens a slot combinationally, and an entry
// pushed into an empty queue is only visible at the head next cycle.
module e203_exu_wbck_lq #(
    parameter int DW    = 32,
    parameter int IW    = 5,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [IW-1:0] push_idx,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [IW-1:0] head_idx,
    output logic [DW-1:0] head_dat,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [IW-1:0] idx_mem [DEPTH];
    logic [DW-1:0] dat_mem [DEPTH];
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty      = (wr_ptr == rd_ptr);
    assign push_ready = !full;
    assign do_push    = push_valid && !full;
    assign do_pop     = pop && !empty;
    assign head_idx   = idx_mem[rd_ptr[AW-1:0]];
    assign head_dat   = dat_mem[rd_ptr[AW-1:0]];

    // Pointer update; reset discards whatever the queue held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            idx_mem[wr_ptr[AW-1:0]] <= push_idx;
            dat_mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// Write-back arbiter: picks between the long-pipe queue head and the ALU
// each cycle, guards the ALU against starvation, and registers the
// winner into the single regfile write port. Writes to x0 complete their
// handshake but never raise the write enable.
module e203_exu_wbck_arb
    import e203_exu_wbck_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    e203_exu_wbck_arb_if.slave   bus
);

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    logic [RFIDX_W-1:0]  head_idx;
    logic [XLEN-1:0]     head_dat;
    logic                lq_empty_w;
    logic                head_win;
    logic                alu_win;
    logic                winner_valid;
    logic [RFIDX_W-1:0]  winner_idx;
    logic [XLEN-1:0]     winner_dat;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_nxt;

    e203_exu_wbck_lq #(
        .DW    (XLEN),
        .IW    (RFIDX_W),
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (bus.lp_wbck_valid),
        .push_ready (bus.lp_wbck_ready),
        .push_idx   (bus.lp_wbck_idx),
        .push_dat   (bus.lp_wbck_dat),
        .pop        (head_win),
        .head_idx   (head_idx),
        .head_dat   (head_dat),
        .empty      (lq_empty_w)
    );

    assign bus.lq_empty = lq_empty_w;

    // Queue head wins unless the ALU has been held off long enough; the ALU
    // ready does not depend on its own valid so an empty queue never stalls it.
    always_comb begin
        head_win           = !lq_empty_w && (starve_cnt < STARVE_LIMIT);
        alu_win            = bus.alu_wbck_valid && !head_win;
        bus.alu_wbck_ready = !head_win;
        winner_valid       = head_win || alu_win;
        winner_idx         = head_win ? head_idx : bus.alu_wbck_idx;
        winner_dat         = head_win ? head_dat : bus.alu_wbck_dat;
    end

    // Count consecutive cycles where a valid ALU result was refused.
    always_comb begin
        starve_nxt = starve_cnt;
        if (alu_win || !bus.alu_wbck_valid) begin
            starve_nxt = '0;
        end else if (starve_cnt != STARVE_LIMIT) begin
            starve_nxt = starve_cnt + STARVE_W'(1);
        end
    end

    // Starve counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_cnt <= '0;
        else        starve_cnt <= starve_nxt;
    end

    // Write enable: one-cycle-late strobe, suppressed for x0 targets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.rf_wbck_wen <= 1'b0;
        else        bus.rf_wbck_wen <= winner_valid && (winner_idx != '0);
    end

    // Write index/data: loaded only when there is a winner, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_wbck_idx <= '0;
            bus.rf_wbck_dat <= '0;
        end else if (winner_valid) begin
            bus.rf_wbck_idx <= winner_idx;
            bus.rf_wbck_dat <= winner_dat;
        end
    end

endmodule
